// File: rtl/mem_arbiter_if.sv
// Requester and memory-port bundle for mem_arbiter.
// The slave modport is the arbiter's view; the master modport is the requester/memory side.
interface mem_arbiter_if;
  logic        req0;
  logic        req1;
  logic [7:0]  addr0;
  logic [7:0]  addr1;
  logic        we0;
  logic        we1;
  logic [31:0] wdata0;
  logic [31:0] wdata1;
  logic        ack0;
  logic        ack1;
  logic [31:0] rdata0;
  logic [31:0] rdata1;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [31:0] mem_rdata;

  modport slave (
    input  req0, req1, addr0, addr1, we0, we1, wdata0, wdata1, mem_rdata,
    output ack0, ack1, rdata0, rdata1, mem_addr, mem_wdata, mem_we
  );

  modport master (
    output req0, req1, addr0, addr1, we0, we1, wdata0, wdata1, mem_rdata,
    input  ack0, ack1, rdata0, rdata1, mem_addr, mem_wdata, mem_we
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester arbiter/sequencer for port A of the 256x32 data memory.
// Define ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins); default is round-robin.
module mem_arbiter (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

  state_e      state_q, state_d;
  logic        owner_q, owner_d;
  logic [7:0]  addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic [31:0] rdata0_q, rdata0_d;
  logic [31:0] rdata1_q, rdata1_d;
  logic        ack0_q, ack0_d;
  logic        ack1_q, ack1_d;
  logic        win;
`ifndef ARB_FIXED_PRIO_EN
  logic        last_q, last_d;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
`ifndef ARB_FIXED_PRIO_EN
      last_q   <= 1'b1;  // "last grant was 1" so requester 0 wins first
`endif
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      we_q     <= we_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
`ifndef ARB_FIXED_PRIO_EN
      last_q   <= last_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    we_d     = we_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    win      = 1'b0;
`ifndef ARB_FIXED_PRIO_EN
    last_d   = last_q;
`endif

    if (bus.req0 && bus.req1) begin
`ifdef ARB_FIXED_PRIO_EN
      win = 1'b0;
`else
      win = ~last_q;
`endif
    end else begin
      win = bus.req1;
    end

    case (state_q)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          owner_d = win;
          addr_d  = win ? bus.addr1  : bus.addr0;
          wdata_d = win ? bus.wdata1 : bus.wdata0;
          we_d    = win ? bus.we1    : bus.we0;
`ifndef ARB_FIXED_PRIO_EN
          last_d  = win;
`endif
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        // Read-before-write: prior contents are captured on the committing edge
        if (owner_q) begin
          rdata1_d = bus.mem_rdata;
          ack1_d   = 1'b1;
        end else begin
          rdata0_d = bus.mem_rdata;
          ack0_d   = 1'b1;
        end
        state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.ack0      = ack0_q;
  assign bus.ack1      = ack1_q;
  assign bus.rdata0    = rdata0_q;
  assign bus.rdata1    = rdata1_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_we    = (state_q == ACCESS) && we_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a behavioural 256x32 memory.
module tb_mem_arbiter;
  logic clk;
  logic rst;
  mem_arbiter_if bus();

  mem_arbiter dut (.clk(clk), .rst(rst), .bus(bus));

  logic [31:0] mem [256];
  logic        pre_we;
  logic [7:0]  pre_addr;
  logic [31:0] pre_data;

  assign bus.mem_rdata = mem[bus.mem_addr];

  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
    else if (pre_we) mem[pre_addr] <= pre_data;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nvec = 0;
  int nfail = 0;

  task automatic preload(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  task automatic issue(input int who, input logic we, input logic [7:0] a, input logic [31:0] d);
    if (who == 0) begin
      bus.we0 = we; bus.addr0 = a; bus.wdata0 = d; bus.req0 = 1'b1;
    end else begin
      bus.we1 = we; bus.addr1 = a; bus.wdata1 = d; bus.req1 = 1'b1;
    end
  endtask

  // Waits (bounded) for the requester's ack, then drops its req; cyc = -1 on timeout.
  task automatic wait_ack(input int who, output int cyc, output int we_cnt,
                          output logic [7:0] we_addr, output int other_ack);
    cyc = -1; we_cnt = 0; we_addr = '0; other_ack = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (bus.mem_we) begin we_cnt++; we_addr = bus.mem_addr; end
      if ((who == 0 && bus.ack1) || (who == 1 && bus.ack0)) other_ack++;
      if ((who == 0 && bus.ack0) || (who == 1 && bus.ack1)) begin
        cyc = c;
        break;
      end
    end
    if (who == 0) bus.req0 = 1'b0; else bus.req1 = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    nvec++; if ({bus.ack0, bus.ack1, bus.mem_we} !== 3'b000) begin nfail++;
      $display("FAIL reset_ctrl ack0/ack1/mem_we=%b expected 000", {bus.ack0, bus.ack1, bus.mem_we}); end
    nvec++; if ({bus.rdata0, bus.rdata1} !== 64'h0) begin nfail++;
      $display("FAIL reset_rdata got %h/%h expected 0/0", bus.rdata0, bus.rdata1); end
    nvec++; if ({bus.mem_addr, bus.mem_wdata} !== 40'h0) begin nfail++;
      $display("FAIL reset_mem_port addr=%h wdata=%h expected 0/0", bus.mem_addr, bus.mem_wdata); end
    rst = 1'b0;
  endtask

  task automatic test_single_read();
    int cyc, wc, oa; logic [7:0] wa;
    preload(8'h10, 32'hDEADBEEF);
    @(negedge clk);
    issue(1, 1'b0, 8'h10, 32'h0);
    wait_ack(1, cyc, wc, wa, oa);
    nvec++; if (cyc !== 2) begin nfail++; $display("FAIL read_latency got %0d expected 2", cyc); end
    nvec++; if (bus.rdata1 !== 32'hDEADBEEF) begin nfail++;
      $display("FAIL read_rdata1 got %h expected deadbeef", bus.rdata1); end
    nvec++; if (wc !== 0) begin nfail++; $display("FAIL read_mem_we got %0d cycles expected 0", wc); end
    nvec++; if (oa !== 0) begin nfail++; $display("FAIL read_ack0 got %0d pulses expected 0", oa); end
  endtask

  task automatic test_write_read();
    int cyc, wc, oa; logic [7:0] wa;
    preload(8'h05, 32'hAAAA5555);
    @(negedge clk);
    issue(0, 1'b1, 8'h05, 32'h12345678);
    wait_ack(0, cyc, wc, wa, oa);
    nvec++; if (cyc !== 2) begin nfail++; $display("FAIL write_latency got %0d expected 2", cyc); end
    nvec++; if (wc !== 1) begin nfail++; $display("FAIL write_we_cycles got %0d expected 1", wc); end
    nvec++; if (wa !== 8'h05) begin nfail++; $display("FAIL write_addr got %h expected 05", wa); end
    nvec++; if (bus.rdata0 !== 32'hAAAA5555) begin nfail++;
      $display("FAIL write_old_data got %h expected aaaa5555", bus.rdata0); end
    nvec++; if (mem[8'h05] !== 32'h12345678) begin nfail++;
      $display("FAIL write_commit got %h expected 12345678", mem[8'h05]); end
    @(negedge clk);
    issue(0, 1'b0, 8'h05, 32'h0);
    wait_ack(0, cyc, wc, wa, oa);
    nvec++; if (bus.rdata0 !== 32'h12345678) begin nfail++;
      $display("FAIL readback got %h expected 12345678", bus.rdata0); end
    nvec++; if (bus.rdata1 !== 32'hDEADBEEF) begin nfail++;
      $display("FAIL other_rdata_kept got %h expected deadbeef", bus.rdata1); end
  endtask

  task automatic test_contention();
    logic [3:0] exp_order;
    int n, last_c;
`ifdef ARB_FIXED_PRIO_EN
    exp_order = 4'b0000;
`else
    exp_order = 4'b1010;
`endif
    pulse_reset();
    issue(0, 1'b0, 8'h10, 32'h0);
    issue(1, 1'b0, 8'h05, 32'h0);
    n = 0; last_c = 0;
    for (int c = 1; c <= 20 && n < 4; c++) begin
      @(negedge clk);
      if (bus.ack0 || bus.ack1) begin
        nvec++; if (bus.ack0 && bus.ack1) begin nfail++;
          $display("FAIL contend_both_ack at txn %0d got 11 expected one-hot", n); end
        nvec++; if (bus.ack1 !== exp_order[n]) begin nfail++;
          $display("FAIL contend_grant txn %0d got %0d expected %0d", n, bus.ack1, exp_order[n]); end
        nvec++; if (c - last_c !== ((n == 0) ? 2 : 3)) begin nfail++;
          $display("FAIL contend_spacing txn %0d got %0d expected %0d", n, c - last_c, (n == 0) ? 2 : 3); end
        last_c = c;
        n++;
      end
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    nvec++; if (n !== 4) begin nfail++; $display("FAIL contend_count got %0d acks expected 4", n); end
    @(negedge clk);
  endtask

  task automatic test_drop_change();
    preload(8'h20, 32'h0BADF00D);
    preload(8'h30, 32'h33333333);
    @(negedge clk);
    issue(0, 1'b0, 8'h20, 32'h0);
    @(negedge clk);
    nvec++; if (bus.mem_addr !== 8'h20) begin nfail++;
      $display("FAIL drop_addr_access got %h expected 20", bus.mem_addr); end
    bus.addr0 = 8'h30; bus.req0 = 1'b0;
    @(negedge clk);
    nvec++; if (bus.ack0 !== 1'b1) begin nfail++; $display("FAIL drop_ack0 got %b expected 1", bus.ack0); end
    nvec++; if (bus.mem_addr !== 8'h20) begin nfail++;
      $display("FAIL drop_addr_resp got %h expected 20", bus.mem_addr); end
    nvec++; if (bus.rdata0 !== 32'h0BADF00D) begin nfail++;
      $display("FAIL drop_rdata0 got %h expected 0badf00d", bus.rdata0); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_access();
    int cyc, wc, oa; logic [7:0] wa;
    preload(8'h40, 32'h11111111);
    @(negedge clk);
    issue(0, 1'b1, 8'h40, 32'h99999999);
    @(negedge clk);
    nvec++; if (bus.mem_we !== 1'b1) begin nfail++; $display("FAIL rst_pre_we got %b expected 1", bus.mem_we); end
    #1 rst = 1'b1;
    bus.req0 = 1'b0;
    #1;
    nvec++; if ({bus.mem_we, bus.ack0, bus.ack1} !== 3'b000) begin nfail++;
      $display("FAIL rst_mid_ctrl got %b expected 000", {bus.mem_we, bus.ack0, bus.ack1}); end
    nvec++; if ({bus.mem_addr, bus.mem_wdata, bus.rdata0, bus.rdata1} !== 104'h0) begin nfail++;
      $display("FAIL rst_mid_data addr=%h wdata=%h r0=%h r1=%h expected 0", bus.mem_addr, bus.mem_wdata, bus.rdata0, bus.rdata1); end
    @(negedge clk);
    nvec++; if (bus.ack0 !== 1'b0) begin nfail++; $display("FAIL rst_no_ack got %b expected 0", bus.ack0); end
    rst = 1'b0;
    nvec++; if (mem[8'h40] !== 32'h11111111) begin nfail++;
      $display("FAIL rst_no_commit got %h expected 11111111", mem[8'h40]); end
    @(negedge clk);
    issue(0, 1'b0, 8'h40, 32'h0);
    wait_ack(0, cyc, wc, wa, oa);
    nvec++; if (cyc !== 2) begin nfail++; $display("FAIL rst_after_latency got %0d expected 2", cyc); end
    nvec++; if (bus.rdata0 !== 32'h11111111) begin nfail++;
      $display("FAIL rst_after_rdata got %h expected 11111111", bus.rdata0); end
  endtask

  task automatic test_idle();
    int bad;
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.mem_we || bus.ack0 || bus.ack1) bad++;
    end
    nvec++; if (bad !== 0) begin nfail++; $display("FAIL idle_quiet got %0d active cycles expected 0", bad); end
    nvec++; if (bus.rdata0 !== 32'h11111111) begin nfail++;
      $display("FAIL idle_rdata0 got %h expected 11111111", bus.rdata0); end
    nvec++; if (bus.rdata1 !== 32'h0) begin nfail++;
      $display("FAIL idle_rdata1 got %h expected 0", bus.rdata1); end
  endtask

  initial begin
    rst = 1'b1;
    pre_we = 1'b0; pre_addr = '0; pre_data = '0;
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus.addr0 = '0; bus.addr1 = '0;
    bus.we0 = 1'b0; bus.we1 = 1'b0;
    bus.wdata0 = '0; bus.wdata1 = '0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    test_reset();
    test_single_read();
    test_write_read();
    test_contention();
    test_drop_change();
    test_reset_mid_access();
    test_idle();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter and sequencer for the single read/write port of the 256 x 32 data memory. Requester 0 is the CPU load/store unit and requester 1 is the debug/loader unit. The block grants one requester at a time and latches its address, data and write-enable. It then drives the memory port for exactly one cycle and returns read data with a one-cycle acknowledge. It sits between the requesters and the memory's write/read port A; the memory's second, read-only port is not touched.

## Interface
- Parameters: none (address width 8 and data width 32 are fixed to match the memory).
- Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- req0 / req1  in  1  access request from requester 0 / 1 (level, held until ack)
- addr0 / addr1  in  8  word address from requester 0 / 1
- we0 / we1  in  1  1 = write, 0 = read
- wdata0 / wdata1  in  32  write data from requester 0 / 1
- ack0 / ack1  out  1  one-cycle completion pulse to requester 0 / 1
- rdata0 / rdata1  out  32  read data for requester 0 / 1, valid when ack is high, held until that requester's next ack
- mem_addr  out  8  memory port address
- mem_wdata  out  32  memory port write data
- mem_we  out  1  memory port write enable
- mem_rdata  in  32  memory port asynchronous read data

## Operation
- FSM states: IDLE, ACCESS, RESP. Reset state is IDLE.
- IDLE: if neither req is high, stay in IDLE. Otherwise pick a winner, latch its addr/we/wdata and the owner id into registers, and go to ACCESS.
- Arbitration is round-robin with a last-grant pointer. If only one req is high, that requester wins. If both are high, the requester not granted last wins. After reset the pointer favours requester 0.
- ACCESS (exactly 1 cycle): mem_addr and mem_wdata come from the latched registers, and mem_we equals the latched we.
  - At the closing edge, mem_rdata is captured into rdata of the owner.
  - At the same edge, the write (if any) commits in memory.
  - Next state is RESP.
- Write accesses return the prior memory contents in rdata (read-before-write). The other requester's rdata is unchanged.
- RESP (exactly 1 cycle): the owner's ack is high. req lines are ignored. Next state is IDLE.
- A requester keeps req high until its ack is seen. It drops req in the cycle after ack, or keeps it high to issue a new request, which IDLE samples.
- A req that drops during ACCESS or RESP does not abort the transaction. It completes and acks normally.
- Input fields are sampled only on the IDLE->ACCESS edge. Changes afterwards have no effect on the current transaction.
- mem_we is low in IDLE and RESP under all conditions.

## Timing
- Latency from req sampled high in IDLE to ack high: 2 cycles (IDLE edge, then ACCESS, then RESP).
- Throughput: one access per 3 cycles. With both requesters continuously requesting, grants alternate 0,1,0,1.
- Reset values:
  - ack0 = ack1 = 0
  - rdata0 = rdata1 = 0
  - mem_addr = 0, mem_wdata = 0, mem_we = 0
  - FSM = IDLE, pointer favours requester 0
- Reset asserted mid-transaction (ACCESS or RESP):
  - FSM returns to IDLE immediately and all outputs go to their reset values.
  - No ack is issued.
  - A write is not committed unless the clock edge closing ACCESS occurs before rst asserts.
- The ack is a registered output. All memory-port outputs are driven from registers or the FSM decode only; there is no combinational path from req to mem_we.

## Configuration
- ARB_FIXED_PRIO_EN is the only configuration macro.
- Defined: fixed priority. When both req lines are high in IDLE, requester 0 always wins. The pointer register is removed.
- Undefined (default): round-robin as described above.

## Test plan
- Single read: preload mem[0x10]=0xDEADBEEF; req1=1, we1=0, addr1=0x10 -> ack1 high exactly 2 cycles after sample, rdata1=0xDEADBEEF, mem_we never high, ack0 stays 0.
- Write then read: req0 writes 0x12345678 to 0x05 (mem holds 0xAAAA5555) -> mem_we high for exactly 1 cycle with mem_addr=0x05, rdata0=0xAAAA5555 at ack0. A following read of 0x05 -> rdata0=0x12345678.
- Contention: req0 and req1 both held high for 4 transactions -> grant order 0,1,0,1, ack pulses every 3 cycles. With ARB_FIXED_PRIO_EN defined -> order 0,0,0,0 and ack1 stays 0.
- Drop/change mid-transaction: req0 read of addr 0x20; addr0 changed to 0x30 and req0 dropped during ACCESS -> mem_addr=0x20 throughout, ack0 still pulses, rdata0=mem[0x20].
- Reset mid-ACCESS on a write to 0x40: rst pulsed during ACCESS before the clock edge -> mem[0x40] unchanged, no ack, all outputs 0, FSM in IDLE. The next request is serviced normally.
- Idle stability: no requests for 20 cycles -> mem_we=0, ack0=ack1=0, rdata registers unchanged.
